// File: rtl/mem_access_ctrl_pkg.sv
// Shared types, funct3 encodings and request decode for the load/store controller.
package mem_access_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // Latched access descriptor: direction, size/sign and byte offset in the word.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] offs;
  } lsu_op_t;

  // Misaligned or unsupported accesses are answered without touching memory.
  function automatic logic op_is_err(lsu_op_t op);
    logic err;
    err = 1'b0;
    if (op.we) begin
      case (op.funct3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = op.offs[0];
        F3_SW:   err = |op.offs;
        default: err = 1'b1;
      endcase
    end else begin
      case (op.funct3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = op.offs[0];
        F3_LW:         err = |op.offs;
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Combinational lane logic: load extract/extend, store lane replication,
// byte-enable generation and read-modify-write merge.
module mem_access_ctrl_align
  import mem_access_ctrl_pkg::*;
(
  input  lsu_op_t           op_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_data_c_o,
  output logic [DATA_W-1:0] lane_data_c_o,
  output logic [BE_W-1:0]   lane_be_c_o,
  output logic [DATA_W-1:0] merge_data_c_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: pick the addressed lane and extend it.
  always_comb begin
    byte_sel      = rdata_i[{op_i.offs, 3'b000} +: 8];
    half_sel      = op_i.offs[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_data_c_o = '0;
    case (op_i.funct3)
      F3_LB:   load_data_c_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data_c_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LH:   load_data_c_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_data_c_o = {{(DATA_W-16){1'b0}}, half_sel};
      F3_LW:   load_data_c_o = rdata_i;
      default: load_data_c_o = '0;
    endcase
  end

  // Store path: data replicated to every lane, enables mark the target lanes.
  always_comb begin
    lane_data_c_o = wdata_i;
    lane_be_c_o   = '0;
    if (op_i.we) begin
      case (op_i.funct3)
        F3_SB: begin
          lane_data_c_o = {4{wdata_i[7:0]}};
          lane_be_c_o   = 4'b0001 << op_i.offs;
        end
        F3_SH: begin
          lane_data_c_o = {2{wdata_i[15:0]}};
          lane_be_c_o   = 4'b0011 << {op_i.offs[1], 1'b0};
        end
        default: begin
          lane_data_c_o = wdata_i;
          lane_be_c_o   = '1;
        end
      endcase
    end
  end

  always_comb begin
    merge_data_c_o = rdata_i;
    for (int k = 0; k < int'(BE_W); k++) begin
      if (lane_be_c_o[k]) merge_data_c_o[8*k +: 8] = lane_data_c_o[8*k +: 8];
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between execute and a fixed-latency data memory:
// request/response handshakes, access FSM, latency counter and data registers.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned USE_BYTE_EN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [3:0]        mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int unsigned WADDR_W = ADDR_W - 2;
  localparam bit          BE_MODE = (USE_BYTE_EN != 0);

  state_e               state_q, state_d;
  lsu_op_t              op_q, op_d, req_op, align_op;
  logic [WADDR_W-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d, align_wdata;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic [3:0]           be_q, be_d;
  logic [XLEN-1:0]      mwdata_q, mwdata_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]      resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic [XLEN-1:0]      load_data_c, lane_data_c, merge_data_c;
  logic [3:0]           lane_be_c;

  assign req_op = {req_we_i, req_funct3_i, req_addr_i[1:0]};

  // In IDLE the lane logic formats the incoming store; afterwards the latched one.
  assign align_op    = (state_q == ST_IDLE) ? req_op : op_q;
  assign align_wdata = (state_q == ST_IDLE) ? req_wdata_i : wdata_q;

  mem_access_ctrl_align u_align (
    .op_i           (align_op),
    .rdata_i        (mem_rdata_i),
    .wdata_i        (align_wdata),
    .load_data_c_o  (load_data_c),
    .lane_data_c_o  (lane_data_c),
    .lane_be_c_o    (lane_be_c),
    .merge_data_c_o (merge_data_c)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    be_d         = be_q;
    mwdata_d     = mwdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          op_d        = req_op;
          waddr_d     = req_addr_i[ADDR_W-1:2];
          wdata_d     = req_wdata_i;
          req_ready_d = 1'b0;
          if (op_is_err(req_op)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!req_we_i || (!BE_MODE && req_funct3_i != F3_SW)) begin
            state_d = ST_RD;
            rd_en_d = 1'b1;
          end else begin
            state_d  = ST_WR;
            wr_en_d  = 1'b1;
            be_d     = lane_be_c;
            mwdata_d = lane_data_c;
          end
        end
      end
      ST_RD: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(MEM_LAT);
      end
      // Read data is valid while the count sits at 1.
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (op_q.we) begin
            state_d  = ST_WR;
            wr_en_d  = 1'b1;
            be_d     = '1;
            mwdata_d = merge_data_c;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = load_data_c;
          end
        end
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      be_q         <= '0;
      mwdata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      be_q         <= be_d;
      mwdata_q     <= mwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = waddr_q;
  assign mem_rd_en_o  = rd_en_q;
  assign mem_wr_en_o  = wr_en_q;
  assign mem_be_o     = be_q;
  assign mem_wdata_o  = mwdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: instance 0 is MEM_LAT=1 with read-modify-write stores,
// instance 1 is MEM_LAT=3 with byte-enable stores; each has its own memory model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_f3     [2];
  logic [7:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [5:0]  mem_addr   [2];
  logic        rd_en      [2];
  logic        wr_en      [2];
  logic [3:0]  be         [2];
  logic [31:0] wdata      [2];
  logic [31:0] rdata      [2];

  mem_access_ctrl #(.XLEN(32), .ADDR_W(8), .MEM_LAT(1), .USE_BYTE_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_funct3_i(req_f3[0]), .req_addr_i(req_addr[0]),
    .req_wdata_i(req_wdata[0]), .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]), .mem_addr_o(mem_addr[0]),
    .mem_rd_en_o(rd_en[0]), .mem_wr_en_o(wr_en[0]), .mem_be_o(be[0]),
    .mem_wdata_o(wdata[0]), .mem_rdata_i(rdata[0]));

  mem_access_ctrl #(.XLEN(32), .ADDR_W(8), .MEM_LAT(3), .USE_BYTE_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_funct3_i(req_f3[1]), .req_addr_i(req_addr[1]),
    .req_wdata_i(req_wdata[1]), .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]), .mem_addr_o(mem_addr[1]),
    .mem_rd_en_o(rd_en[1]), .mem_wr_en_o(wr_en[1]), .mem_be_o(be[1]),
    .mem_wdata_o(wdata[1]), .mem_rdata_i(rdata[1]));

  // Memory model: byte-enable writes, read data valid exactly MEM_LAT cycles after the strobe.
  logic [31:0] mem [2][64];
  logic [31:0] pd  [2][7];
  logic        pv  [2][7];
  logic        mem_init;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_init) begin
        for (int w = 0; w < 64; w++) mem[i][w] <= 32'h0;
        mem[i][4] <= 32'h8081_7F01;
        mem[i][8] <= 32'h1122_3344;
      end else if (wr_en[i]) begin
        for (int k = 0; k < 4; k++)
          if (be[i][k]) mem[i][mem_addr[i]][8*k +: 8] <= wdata[i][8*k +: 8];
      end
      pv[i][0] <= rd_en[i];
      pd[i][0] <= mem[i][mem_addr[i]];
      for (int s = 1; s < 7; s++) begin
        pv[i][s] <= pv[i][s-1];
        pd[i][s] <= pd[i][s-1];
      end
    end
  end

  assign rdata[0] = pv[0][0] ? pd[0][0] : 32'hDEAD_BEEF;
  assign rdata[1] = pv[1][2] ? pd[1][2] : 32'hDEAD_BEEF;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          inst;
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic        chk_mem;
    logic [31:0] exp_mem;
    int          stall;
  } vec_t;

  function automatic vec_t mkv(int inst, logic we, logic [2:0] f3, logic [7:0] a, logic [31:0] wd);
    vec_t v;
    v.inst = inst; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_rdata = 32'h0; v.exp_err = 1'b0; v.exp_lat = 0; v.exp_rd = 0; v.exp_wr = 0;
    v.exp_be = 4'h0; v.exp_wd = 32'h0; v.chk_mem = 1'b0; v.exp_mem = 32'h0; v.stall = 0;
    return v;
  endfunction

  // Load: instance 0 answers at A+3, instance 1 (MEM_LAT=3) at A+5.
  function automatic vec_t ld(int inst, logic [2:0] f3, logic [7:0] a, logic [31:0] exp);
    vec_t v;
    v = mkv(inst, 1'b0, f3, a, 32'h0);
    v.exp_rdata = exp; v.exp_rd = 1; v.exp_lat = (inst == 0) ? 3 : 5;
    return v;
  endfunction

  function automatic vec_t er(int inst, logic we, logic [2:0] f3, logic [7:0] a);
    vec_t v;
    v = mkv(inst, we, f3, a, 32'h1234_5678);
    v.exp_err = 1'b1; v.exp_lat = 1;
    return v;
  endfunction

  function automatic vec_t st(int inst, logic [2:0] f3, logic [7:0] a, logic [31:0] wd,
                              logic [3:0] ebe, logic [31:0] ewd, logic [31:0] emem);
    vec_t v;
    v = mkv(inst, 1'b1, f3, a, wd);
    v.exp_be = ebe; v.exp_wd = ewd; v.chk_mem = 1'b1; v.exp_mem = emem;
    if (inst == 0 && f3 != 3'd2) begin
      v.exp_lat = 4; v.exp_rd = 1; v.exp_wr = 3;
    end else begin
      v.exp_lat = 2; v.exp_wr = 1;
    end
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int i, lat, rd_c, wr_c, rd_n, wr_n;
    logic [3:0] g_be;
    logic [31:0] g_wd, g_rdata;
    logic g_err;
    bit bad_ready, bad_addr, overlap, bad_stall;
    string p;
    i = v.inst; lat = 0; rd_c = 0; wr_c = 0; rd_n = 0; wr_n = 0;
    g_be = 4'h0; g_wd = 32'h0;
    bad_ready = 0; bad_addr = 0; overlap = 0; bad_stall = 0;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({p, " req_ready idle"}, 32'(req_ready[i]), 32'd1);
    chk({p, " resp_valid idle"}, 32'(resp_valid[i]), 32'd0);
    req_valid[i] = 1'b1; req_we[i] = v.we; req_f3[i] = v.f3;
    req_addr[i] = v.addr; req_wdata[i] = v.wdata;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0; req_f3[i] = ~v.f3; req_addr[i] = 8'hFC; req_wdata[i] = 32'h5555_5555;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (req_ready[i]) bad_ready = 1;
      if (rd_en[i] && wr_en[i]) overlap = 1;
      if ((rd_en[i] || wr_en[i]) && mem_addr[i] != v.addr[7:2]) bad_addr = 1;
      if (rd_en[i]) begin rd_n++; if (rd_c == 0) rd_c = c; end
      if (wr_en[i]) begin wr_n++; wr_c = c; g_be = be[i]; g_wd = wdata[i]; end
      if (resp_valid[i]) begin lat = c; break; end
    end
    g_rdata = resp_rdata[i]; g_err = resp_err[i];
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      if (!resp_valid[i] || resp_rdata[i] !== g_rdata || resp_err[i] !== g_err || req_ready[i])
        bad_stall = 1;
    end
    chk({p, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({p, " rdata"}, g_rdata, v.exp_rdata);
    chk({p, " err"}, 32'(g_err), 32'(v.exp_err));
    chk({p, " rd cycle"}, 32'(rd_c), 32'(v.exp_rd));
    chk({p, " rd count"}, 32'(rd_n), (v.exp_rd != 0) ? 32'd1 : 32'd0);
    chk({p, " wr cycle"}, 32'(wr_c), 32'(v.exp_wr));
    chk({p, " wr count"}, 32'(wr_n), (v.exp_wr != 0) ? 32'd1 : 32'd0);
    chk({p, " req_ready low while busy"}, 32'(bad_ready), 32'd0);
    chk({p, " strobe overlap"}, 32'(overlap), 32'd0);
    chk({p, " mem_addr at strobe"}, 32'(bad_addr), 32'd0);
    if (v.exp_wr != 0) begin
      chk({p, " be"}, 32'(g_be), 32'(v.exp_be));
      chk({p, " wdata"}, g_wd, v.exp_wd);
    end
    if (v.stall != 0) chk({p, " stall stable"}, 32'(bad_stall), 32'd0);
    resp_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[i] = 1'b0;
    if (v.chk_mem) chk({p, " mem word"}, mem[i][v.addr[7:2]], v.exp_mem);
  endtask

  // Start an access, assert reset after 'cyc' busy cycles, check everything drops at once.
  task automatic reset_mid(input int i, input logic we, input logic [2:0] f3,
                           input logic [7:0] a, input int cyc, input string nm);
    @(negedge clk);
    req_valid[i] = 1'b1; req_we[i] = we; req_f3[i] = f3; req_addr[i] = a; req_wdata[i] = 32'h33;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    repeat (cyc) @(negedge clk);
    if (cyc == 1) chk({nm, " rd strobe before reset"}, 32'(rd_en[i]), 32'd1);
    rst_n[i] = 1'b0;
    #1;
    chk({nm, " rd_en after reset"}, 32'(rd_en[i]), 32'd0);
    chk({nm, " wr_en after reset"}, 32'(wr_en[i]), 32'd0);
    chk({nm, " resp_valid after reset"}, 32'(resp_valid[i]), 32'd0);
    chk({nm, " req_ready after reset"}, 32'(req_ready[i]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n[i] = 1'b1;
  endtask

  vec_t vq[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_f3[i] = 3'd0;
      req_addr[i] = 8'h0; req_wdata[i] = 32'h0; resp_ready[i] = 1'b0;
    end
    mem_init = 1'b1;

    vq.push_back(ld(0, 3'd0, 8'h11, 32'h0000_007F));
    vq.push_back(ld(0, 3'd0, 8'h12, 32'hFFFF_FF81));
    vq.push_back(ld(0, 3'd4, 8'h13, 32'h0000_0080));
    vq.push_back(ld(0, 3'd5, 8'h12, 32'h0000_8081));
    vq.push_back(ld(0, 3'd1, 8'h12, 32'hFFFF_8081));
    vq.push_back(ld(0, 3'd1, 8'h10, 32'h0000_7F01));
    vq.push_back(ld(0, 3'd2, 8'h10, 32'h8081_7F01));
    vq.push_back(er(0, 1'b0, 3'd1, 8'h13));
    vq.push_back(er(0, 1'b0, 3'd5, 8'h11));
    vq.push_back(er(0, 1'b0, 3'd2, 8'h12));
    vq.push_back(er(0, 1'b0, 3'd3, 8'h10));
    vq.push_back(er(0, 1'b0, 3'd6, 8'h10));
    vq.push_back(er(0, 1'b0, 3'd7, 8'h10));
    vq.push_back(er(0, 1'b1, 3'd3, 8'h10));
    vq.push_back(er(0, 1'b1, 3'd4, 8'h10));
    vq.push_back(er(0, 1'b1, 3'd1, 8'h11));
    vq.push_back(er(0, 1'b1, 3'd2, 8'h12));
    vq.push_back(st(0, 3'd0, 8'h12, 32'h1234_56AA, 4'hF, 32'h80AA_7F01, 32'h80AA_7F01));
    vq.push_back(ld(0, 3'd2, 8'h10, 32'h80AA_7F01));
    vq.push_back(st(0, 3'd1, 8'h20, 32'hFFFF_BEEF, 4'hF, 32'h1122_BEEF, 32'h1122_BEEF));
    vq.push_back(st(0, 3'd0, 8'h23, 32'h0000_0077, 4'hF, 32'h7722_BEEF, 32'h7722_BEEF));
    vq.push_back(st(0, 3'd2, 8'h24, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D));
    vq.push_back(ld(0, 3'd1, 8'h22, 32'h0000_7722));
    vq.push_back(ld(0, 3'd0, 8'h20, 32'hFFFF_FFEF));
    vq.push_back(st(1, 3'd1, 8'h12, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'hBEEF_7F01));
    vq.push_back(st(1, 3'd0, 8'h11, 32'hFFFF_FF5A, 4'b0010, 32'h5A5A_5A5A, 32'hBEEF_5A01));
    vq.push_back(ld(1, 3'd2, 8'h10, 32'hBEEF_5A01));
    vq[$].stall = 5;
    vq.push_back(ld(1, 3'd0, 8'h11, 32'h0000_005A));
    vq.push_back(ld(1, 3'd1, 8'h12, 32'hFFFF_BEEF));
    vq.push_back(st(1, 3'd0, 8'h10, 32'h0000_0080, 4'b0001, 32'h8080_8080, 32'hBEEF_5A80));
    vq.push_back(st(1, 3'd2, 8'h20, 32'h0102_0304, 4'hF, 32'h0102_0304, 32'h0102_0304));
    vq.push_back(er(1, 1'b1, 3'd1, 8'h13));
    vq.push_back(ld(1, 3'd5, 8'h10, 32'h0000_5A80));

    repeat (2) @(posedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d req_ready", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("rst%0d resp_valid", i), 32'(resp_valid[i]), 32'd0);
      chk($sformatf("rst%0d strobes", i), {30'h0, rd_en[i], wr_en[i]}, 32'd0);
      chk($sformatf("rst%0d rdata", i), resp_rdata[i], 32'd0);
      chk($sformatf("rst%0d err", i), 32'(resp_err[i]), 32'd0);
      chk($sformatf("rst%0d mem_addr/be", i), {22'h0, mem_addr[i], be[i]}, 32'd0);
      chk($sformatf("rst%0d wdata", i), wdata[i], 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    for (int n = 0; n < vq.size(); n++) run_vec(n, vq[n]);

    // Reset during the read of an RMW store (instance 0) and during WAIT of a load (instance 1).
    reset_mid(0, 1'b1, 3'd0, 8'h10, 1, "rmw reset");
    run_vec(100, ld(0, 3'd2, 8'h10, 32'h80AA_7F01));
    reset_mid(1, 1'b0, 3'd2, 8'h10, 2, "wait reset");
    run_vec(101, ld(1, 3'd2, 8'h10, 32'hBEEF_5A80));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
